// File: rtl/xor_fold_seq.sv
// xor_fold_seq: multi-cycle XOR signature sequencer.
//
// Reduces an IN_W-bit word to an 8-bit signature by walking it 16 bits at a
// time (LSB chunk first). Each chunk is folded to one byte (low ^ high) and the
// fold results are XOR-accumulated. Only one 16-to-8 fold stage exists, so the
// datapath stays one slice wide whatever IN_W is.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   producer has a word on in_data
//   in_ready   block can accept a word this cycle (IDLE)
//   in_data    word to fold, sampled only at the accept edge
//   abort      drops the job in flight (FOLD or DONE), ignored in IDLE
//   out_valid  out_sig holds a completed signature (DONE)
//   out_ready  consumer accepts out_sig
//   out_sig    folded signature, stable while out_valid is high
//   busy       high while folding
//   done_cnt   number of signatures delivered, wraps
//
// IN_W must be a multiple of 16 and at least 16.
module xor_fold_seq #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sig,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int unsigned N    = IN_W / 16;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFold,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   shift_q, shift_d;
    logic [7:0]        acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        done_cnt_d = done_cnt_q;

        case (state_q)
            StIdle: begin
                // abort is deliberately not looked at here.
                if (in_valid) begin
                    shift_d = in_data;
                    acc_d   = 8'h00;
                    cnt_d   = '0;
                    state_d = StFold;
                end
            end
            StFold: begin
                if (abort) begin
                    acc_d   = 8'h00;
                    state_d = StIdle;
                end else begin
                    acc_d   = acc_q ^ shift_q[7:0] ^ shift_q[15:8];
                    shift_d = shift_q >> 16;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // abort wins over a simultaneous output handshake.
                if (abort) begin
                    acc_d   = 8'h00;
                    state_d = StIdle;
                end else if (out_ready) begin
                    done_cnt_d = done_cnt_q + CNT_W'(1);
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= 8'h00;
            cnt_q      <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Shift register content is irrelevant after reset, so it is not reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // Output decode.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StFold);
        out_valid = (state_q == StDone);
        out_sig   = acc_q;
        done_cnt  = done_cnt_q;
    end

endmodule
